// File: rtl/scr_breakdown_monitor.sv
// Multi-channel SCR breakdown / BOD monitor: per-channel light conditioning,
// trigger edge detection and a window-classification FSM with a consecutive-fail trip.
//
// state | meaning
// IDLE  | waiting for a trigger edge
// EARLY | cnt 1..T_BOD, a light edge marks BOD
// BLANK | cnt T_BOD+1..T_BLANK, light edges ignored
// LATE  | cnt T_BLANK+1..T_WIN, light edge or timeout posts the result
module scr_breakdown_monitor #(
  parameter int N_CH     = 2,
  parameter int CNT_W    = 20,
  parameter int DEB_LEN  = 8,
  parameter int T_BOD    = 25000,
  parameter int T_BLANK  = 42400,
  parameter int T_WIN    = 500000,
  parameter int FAIL_LIM = 3
) (
  input  logic            i_clk_50m,
  input  logic            i_rst,
  input  logic [N_CH-1:0] i_signal,
  input  logic [N_CH-1:0] i_signal_forward,
  input  logic [N_CH-1:0] i_signal_negative,
  input  logic            i_signal_forbid,
  output logic [N_CH-1:0] o_SCR_forward_state,
  output logic [N_CH-1:0] o_SCR_negative_state,
  output logic [N_CH-1:0] o_SCR_forward_BOD,
  output logic [N_CH-1:0] o_SCR_negative_BOD,
  output logic [N_CH-1:0] o_result_valid,
  output logic [N_CH-1:0] o_trip
);

  localparam int DEB_W  = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
  localparam int FAIL_W = $clog2(FAIL_LIM + 1);

  localparam logic [DEB_W-1:0]  DEB_TC  = DEB_W'(DEB_LEN - 1);
  localparam logic [CNT_W-1:0]  T_BOD_C = CNT_W'(T_BOD);
  localparam logic [CNT_W-1:0]  T_BLK_C = CNT_W'(T_BLANK);
  localparam logic [CNT_W-1:0]  T_WIN_C = CNT_W'(T_WIN);
  localparam logic [FAIL_W-1:0] FAIL_C  = FAIL_W'(FAIL_LIM);
  localparam logic [FAIL_W-1:0] FAIL_M1 = FAIL_W'(FAIL_LIM - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EARLY = 2'd1,
    ST_BLANK = 2'd2,
    ST_LATE  = 2'd3
  } state_t;

  // Reset asserts asynchronously but releases on a clock edge.
  logic rst_meta_q, rst_sync_q;

  always_ff @(posedge i_clk_50m or posedge i_rst) begin
    if (i_rst) begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= 1'b1;
    end else begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= rst_meta_q;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic             sync1_q, sync2_q, deb_q, light_edge_q;
    logic [DEB_W-1:0] deb_cnt_q;
    logic             fwd_prev_q, neg_prev_q;
    logic             fwd_edge, neg_edge;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [FAIL_W-1:0] fail_q;
    logic              pol_f_q, bod_q, lock_q;
    logic              fwd_state_q, neg_state_q, fwd_bod_q, neg_bod_q, valid_q, trip_q;

    assign fwd_edge = i_signal_forward[k]  & ~fwd_prev_q;
    assign neg_edge = i_signal_negative[k] & ~neg_prev_q;

    always_ff @(posedge i_clk_50m or posedge rst_sync_q) begin
      if (rst_sync_q) begin
        sync1_q      <= 1'b0;
        sync2_q      <= 1'b0;
        deb_q        <= 1'b0;
        deb_cnt_q    <= '0;
        light_edge_q <= 1'b0;
        fwd_prev_q   <= 1'b0;
        neg_prev_q   <= 1'b0;
      end else begin
        sync1_q      <= i_signal[k];
        sync2_q      <= sync1_q;
        fwd_prev_q   <= i_signal_forward[k];
        neg_prev_q   <= i_signal_negative[k];
        light_edge_q <= 1'b0;
        if (sync2_q == deb_q) begin
          deb_cnt_q <= '0;
        end else if (deb_cnt_q == DEB_TC) begin
          deb_q        <= sync2_q;
          deb_cnt_q    <= '0;
          light_edge_q <= sync2_q;
        end else begin
          deb_cnt_q <= deb_cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge i_clk_50m or posedge rst_sync_q) begin
      if (rst_sync_q) begin
        state_q     <= ST_IDLE;
        cnt_q       <= '0;
        pol_f_q     <= 1'b1;
        bod_q       <= 1'b0;
        fail_q      <= '0;
        lock_q      <= 1'b0;
        fwd_state_q <= 1'b1;
        neg_state_q <= 1'b1;
        fwd_bod_q   <= 1'b1;
        neg_bod_q   <= 1'b1;
        valid_q     <= 1'b0;
        trip_q      <= 1'b1;
      end else begin
        valid_q <= 1'b0;
        if (i_signal_forbid) begin
          state_q     <= ST_IDLE;
          cnt_q       <= '0;
          fwd_state_q <= 1'b1;
          neg_state_q <= 1'b1;
          fwd_bod_q   <= 1'b1;
          neg_bod_q   <= 1'b1;
        end else if (fwd_edge || neg_edge) begin
          // Any trigger (re)starts the window; forward wins a tie.
          state_q <= ST_EARLY;
          cnt_q   <= CNT_W'(1);
          pol_f_q <= fwd_edge;
          bod_q   <= 1'b0;
        end else begin
          case (state_q)
            ST_IDLE: begin
            end
            ST_EARLY: begin
              cnt_q <= cnt_q + 1'b1;
              if (light_edge_q) bod_q <= 1'b1;
              if (cnt_q == T_BOD_C) state_q <= ST_BLANK;
            end
            ST_BLANK: begin
              cnt_q <= cnt_q + 1'b1;
              if (cnt_q == T_BLK_C) state_q <= ST_LATE;
            end
            ST_LATE: begin
              if (light_edge_q || cnt_q == T_WIN_C) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                valid_q <= 1'b1;
                if (pol_f_q) begin
                  neg_state_q <= ~light_edge_q;
                  fwd_bod_q   <= bod_q;
                end else begin
                  fwd_state_q <= ~light_edge_q;
                  neg_bod_q   <= bod_q;
                end
                // Once the fail limit has tripped, only reset can clear the trip.
                if (light_edge_q) begin
                  fail_q <= '0;
                  if (!lock_q) trip_q <= 1'b0;
                end else if (fail_q >= FAIL_M1) begin
                  fail_q <= FAIL_C;
                  lock_q <= 1'b1;
                  trip_q <= 1'b1;
                end else begin
                  fail_q <= fail_q + 1'b1;
                end
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
            default: state_q <= ST_IDLE;
          endcase
        end
      end
    end

    assign o_SCR_forward_state[k]  = fwd_state_q;
    assign o_SCR_negative_state[k] = neg_state_q;
    assign o_SCR_forward_BOD[k]    = fwd_bod_q;
    assign o_SCR_negative_BOD[k]   = neg_bod_q;
    assign o_result_valid[k]       = valid_q;
    assign o_trip[k]               = trip_q;
  end

endmodule
